// File: rtl/gpio_pkg.sv
// Shared types and constants for the GPIO key/LED controller.
package gpio_pkg;

  typedef enum logic [1:0] {
    LED_OFF  = 2'b00,
    LED_ON   = 2'b01,
    LED_SLOW = 2'b10,
    LED_FAST = 2'b11
  } led_mode_t;

  localparam int PHASE_W = 4;

  // LED-on value for a given mode at the current blink phase.
  function automatic logic led_value(input led_mode_t mode, input logic [PHASE_W-1:0] phase);
    logic on;
    on = 1'b0;
    case (mode)
      LED_OFF:  on = 1'b0;
      LED_ON:   on = 1'b1;
      LED_SLOW: on = phase[3];
      LED_FAST: on = phase[1];
      default:  on = 1'b0;
    endcase
    return on;
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One key channel: 2-flop synchronizer, debounce counter and sticky
// press/release event flags.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in_n,
  input  logic evt_clr,
  output logic key_level,
  output logic key_press_evt,
  output logic key_release_evt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg, sync2_reg;
  logic             synced;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             level_reg, level_next;
  logic             press_reg, press_next;
  logic             release_reg, release_next;

  // Synchronizer idles at 1 so a reset looks like a released pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= key_in_n;
      sync2_reg <= sync1_reg;
    end
  end

  assign synced = ~sync2_reg;

  always_comb begin
    cnt_next     = cnt_reg;
    level_next   = level_reg;
    press_next   = press_reg;
    release_next = release_reg;

    if (synced == level_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_next   = '0;
      level_next = synced;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end

    // Clear first so a coincident set takes priority.
    if (evt_clr) begin
      press_next   = 1'b0;
      release_next = 1'b0;
    end
    if (level_next && !level_reg) press_next = 1'b1;
    if (!level_next && level_reg) release_next = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      level_reg   <= 1'b0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      level_reg   <= level_next;
      press_reg   <= press_next;
      release_reg <= release_next;
    end
  end

  assign key_level       = level_reg;
  assign key_press_evt   = press_reg;
  assign key_release_evt = release_reg;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: debounced push-buttons with sticky events and
// mode-selectable LEDs blinking from one shared prescaler/phase.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int NUM_LEDS        = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_DIV       = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_KEYS-1:0]   key_in_n,
  output logic [NUM_KEYS-1:0]   key_level,
  output logic [NUM_KEYS-1:0]   key_press_evt,
  output logic [NUM_KEYS-1:0]   key_release_evt,
  input  logic [NUM_KEYS-1:0]   key_evt_clr,
  input  logic [2*NUM_LEDS-1:0] led_mode,
  output logic [NUM_LEDS-1:0]   led_out_n
);

  localparam int PRESC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BLINK_DIV - 1);

  genvar gi;

  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      gpio_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk            (clk),
        .rst            (rst),
        .key_in_n       (key_in_n[gi]),
        .evt_clr        (key_evt_clr[gi]),
        .key_level      (key_level[gi]),
        .key_press_evt  (key_press_evt[gi]),
        .key_release_evt(key_release_evt[gi])
      );
    end
  endgenerate

  logic [PRESC_W-1:0] presc_reg;
  logic               blink_tick;
  logic [PHASE_W-1:0] phase_reg;
  logic [NUM_LEDS-1:0] led_on;
  logic [NUM_LEDS-1:0] led_out_n_reg;

  assign blink_tick = (presc_reg == PRESC_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
      phase_reg <= '0;
    end else begin
      presc_reg <= blink_tick ? '0 : presc_reg + 1'b1;
      if (blink_tick) phase_reg <= phase_reg + 1'b1;
    end
  end

  // Every LED reads the same phase, keeping blinking LEDs in lock-step.
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
      assign led_on[gi] = led_value(led_mode_t'(led_mode[2*gi +: 2]), phase_reg);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) led_out_n_reg <= '1;
    else     led_out_n_reg <= ~led_on;
  end

  assign led_out_n = led_out_n_reg;

endmodule

// File: doc/gpio_ctrl.md
GPIO_CTRL -- requirements
Module: gpio_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 2, number of push-button inputs (1..32).
REQ-002 SHALL have parameter NUM_LEDS, default 2, number of LED outputs (1..32).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, stable-input cycles required before a key level change is accepted (>=2).
REQ-004 SHALL have parameter BLINK_DIV, default 5_000_000, clock cycles per blink tick (>=2).
REQ-005 clk  input  1  single clock for all logic.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 key_in_n  input  NUM_KEYS  raw asynchronous key pins, active-low.
REQ-008 key_level  output  NUM_KEYS  debounced key state, 1 = pressed.
REQ-009 key_press_evt  output  NUM_KEYS  sticky flag, set on debounced press.
REQ-010 key_release_evt  output  NUM_KEYS  sticky flag, set on debounced release.
REQ-011 key_evt_clr  input  NUM_KEYS  one-cycle pulse clearing both sticky flags of that key.
REQ-012 led_mode  input  2*NUM_LEDS  per-LED mode, LED i uses bits [2i+1:2i].
REQ-013 led_out_n  output  NUM_LEDS  LED pins, active-low, registered.

Function
REQ-014 Each key_in_n bit SHALL pass through a 2-flop synchronizer, then be inverted to active-high.
REQ-015 Per key: synced == key_level -> debounce counter cleared to 0; synced != key_level -> counter increments.
REQ-016 When the counter reaches DEBOUNCE_CYCLES-1 with synced still differing, key_level SHALL toggle on the next edge and the counter SHALL clear to 0.
REQ-017 Any glitch shorter than DEBOUNCE_CYCLES cycles SHALL leave key_level unchanged; the counter restarts from 0 at the glitch's end.
REQ-018 Latency from pin edge to key_level change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles for a clean edge.
REQ-019 key_level 0->1 SHALL set key_press_evt in the same cycle key_level updates; 1->0 SHALL set key_release_evt likewise.
REQ-020 key_evt_clr[i] SHALL clear both flags of key i on the next edge; simultaneous set and clear -> set wins.
REQ-021 Counter width SHALL be $clog2(DEBOUNCE_CYCLES); the counter never wraps.
REQ-022 A free-running prescaler SHALL count 0..BLINK_DIV-1, wrap to 0, and emit a one-cycle tick at BLINK_DIV-1.
REQ-023 A 4-bit phase counter SHALL increment on each tick, wrapping 15->0.
REQ-024 LED mode 00 SHALL drive the LED off; 01 on; 10 slow blink = phase[3]; 11 fast blink = phase[1].
REQ-025 led_out_n[i] SHALL equal the inverse of the LED-on value, registered, one cycle after the led_mode or phase change.
REQ-026 All LEDs in blink modes SHALL share the prescaler and phase so they remain in lock-step.

Reset
REQ-027 While rst=1: key_level=0, key_press_evt=0, key_release_evt=0, led_out_n=all 1 (off).
REQ-028 While rst=1: synchronizer flops=1 (pin inactive), debounce counters=0, prescaler=0, phase=0.
REQ-029 A press held across reset deassertion SHALL produce key_level=1 and key_press_evt=1 after 2 + DEBOUNCE_CYCLES cycles.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count; no event is generated.

Structure
REQ-031 A shared package gpio_pkg SHALL hold the enum led_mode_t (LED_OFF, LED_ON, LED_SLOW, LED_FAST) and a PHASE_W=4 constant.
REQ-032 Synchronizer, debounce counter and edge detect SHALL live in sub-module gpio_debounce, instantiated NUM_KEYS times via generate.
REQ-033 Prescaler, phase and LED muxing SHALL stay in gpio_ctrl.

Verification
(Bench uses DEBOUNCE_CYCLES=16, BLINK_DIV=4, NUM_KEYS=2, NUM_LEDS=2.)
REQ-034 Clean press: key_in_n[0] 1->0 held -> key_level[0]=1 and key_press_evt[0]=1 exactly 18 cycles later; key[1] unaffected.
REQ-035 Bounce: key_in_n[0] low 10 cycles, high 1, low held -> key_level[0] rises 18 cycles after the final fall, not before.
REQ-036 Clear race: key_evt_clr[0]=1 in the same cycle key_press_evt[0] would set -> flag reads 1; clr one cycle later -> flag 0.
REQ-037 Blink: led_mode=4'b1110 (LED0 slow, LED1 fast) from reset -> led_out_n[1] toggles every 8 cycles, led_out_n[0] every 32 cycles.
REQ-038 Mode/reset: led_mode[1:0]=01 -> led_out_n[0]=0 one cycle later; assert rst mid-debounce -> all outputs at reset values, no event after release.
